// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the game CPU and the hiscore engine.
// Pauses the CPU, waits for a stable pause, then lends the port to the hiscore engine.
module hs_ram_arbiter #(
  parameter int          AW      = 11,
  parameter logic [15:0] HS_BASE = 16'h6000,
  parameter int          SETTLE  = 4,
  parameter int          TIMEOUT = 1023
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  input  logic [15:0]   hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  input  logic          hs_access_read,
  input  logic          hs_access_write,
  output logic [7:0]    hs_data_out,
  input  logic          paused,
  output logic          pause_req,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          hs_owner,
  output logic          hs_error
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE - 1);
  // Window end kept 17 bits wide so a window touching 16'hFFFF cannot wrap.
  localparam logic [16:0]   HS_END  = {1'b0, HS_BASE} + 17'(2 ** AW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          pause_req_q;
  logic          hs_owner_q;
  logic          hs_error_q;
  logic          rd_win_q;
  logic [7:0]    hs_data_out_q;

  logic intent;
  logic in_window;

  assign intent    = hs_access_read | hs_access_write;
  assign in_window = (hs_address >= HS_BASE) && ({1'b0, hs_address} < HS_END);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pause_req_q   <= 1'b0;
      hs_owner_q    <= 1'b0;
      hs_error_q    <= 1'b0;
      rd_win_q      <= 1'b0;
      hs_data_out_q <= 8'h00;
    end else begin
      // RAM read data arrives one cycle after the address; qualify it with the window of that address.
      rd_win_q      <= (state_q == S_GRANT) && in_window;
      hs_data_out_q <= rd_win_q ? ram_dout : 8'h00;
      case (state_q)
        S_IDLE: begin
          if (intent) begin
            state_q     <= S_REQ;
            pause_req_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        S_REQ: begin
          if (paused) begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            hs_error_q <= 1'b1;
            state_q    <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!paused) begin
            cnt_q <= '0;
          end else if (cnt_q == ST_LAST) begin
            state_q    <= S_GRANT;
            hs_owner_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GRANT: begin
          if (!intent) begin
            state_q    <= S_RELEASE;
            hs_owner_q <= 1'b0;
          end
        end
        S_RELEASE: begin
          state_q     <= S_IDLE;
          pause_req_q <= 1'b0;
          cnt_q       <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state_q)
      S_IDLE, S_REQ: ram_we = cpu_we;
      S_GRANT: begin
        ram_addr = AW'(hs_address - HS_BASE);
        ram_din  = hs_data_in;
        ram_we   = hs_write & in_window;
      end
      default: ram_we = 1'b0;
    endcase
  end

  assign pause_req   = pause_req_q;
  assign hs_owner    = hs_owner_q;
  assign hs_error    = hs_error_q;
  assign hs_data_out = hs_data_out_q;

endmodule
